// File: rtl/spi_agent_arbiter_pkg.sv
// Shared types and helpers for the two-requester SPI agent arbiter.
// The requester index doubles as the bit position in every 2-bit per-requester vector.
package spi_agent_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_HOLD      = 2'd3
  } state_e;

  localparam logic REQ_UART = 1'b0;
  localparam logic REQ_POLL = 1'b1;

  localparam int MODE_CPHA = 0;
  localparam int MODE_CPOL = 1;

  localparam logic [15:0] HOLD_CNT_MAX = 16'hFFFF;

  // On a tie the requester that did not own the bus last time wins.
  function automatic logic rr_pick(logic [1:0] bid, logic last);
    if (&bid) return ~last;
    return bid[REQ_POLL] ? REQ_POLL : REQ_UART;
  endfunction

  function automatic logic [1:0] onehot(logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_agent_arbiter.sv
// Round-robin owner of the single SPI master agent; one owner holds the bus
// for a whole chip-select session, with an optional idle-hold timeout.
module spi_agent_arbiter
  import spi_agent_arbiter_pkg::*;
#(
  parameter int HOLD_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_req,
  input  logic       r1_req,
  input  logic       r0_cs_n,
  input  logic       r1_cs_n,
  input  logic [7:0] r0_data,
  input  logic [7:0] r1_data,
  input  logic [7:0] r0_clk_div,
  input  logic [7:0] r1_clk_div,
  input  logic [1:0] r0_mode,
  input  logic [1:0] r1_mode,
  output logic       r0_gnt,
  output logic       r1_gnt,
  output logic       r0_rdy,
  output logic       r1_rdy,
  output logic       r0_done,
  output logic       r1_done,
  output logic [7:0] rx_byte,
  output logic [7:0] spi_clk_div,
  output logic       cpol,
  output logic       cpha,
  output logic       transfer_req,
  input  logic       transfer_ready,
  input  logic       transfer_done,
  output logic [7:0] to_agent,
  input  logic [7:0] from_agent,
  output logic       cs_n
);

  localparam logic [15:0] LIMIT_M1 = 16'(HOLD_LIMIT - 1);

  logic [1:0]      req, csn, bid;
  logic [1:0][7:0] data_v, div_v;
  logic [1:0][1:0] mode_v;

  assign req    = {r1_req, r0_req};
  assign csn    = {r1_cs_n, r0_cs_n};
  assign bid    = req | ~csn;
  assign data_v = {r1_data, r0_data};
  assign div_v  = {r1_clk_div, r0_clk_div};
  assign mode_v = {r1_mode, r0_mode};

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  mode_q, mode_d;
  logic        treq_q, treq_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rdy_q, rdy_d;
  logic [1:0]  done_q, done_d;
  logic        win, release_bus;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    hold_d      = hold_q;
    div_d       = div_q;
    mode_d      = mode_q;
    treq_d      = treq_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    gnt_d       = gnt_q;
    rdy_d       = 2'b00;
    done_d      = 2'b00;
    release_bus = 1'b0;
    win         = rr_pick(bid, last_q);

    case (state_q)
      S_IDLE: begin
        if (|bid) begin
          owner_d = win;
          div_d   = div_v[win];
          mode_d  = mode_v[win];
          tx_d    = data_v[win];
          gnt_d   = onehot(win);
          hold_d  = '0;
          if (req[win]) begin
            treq_d  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_ISSUE: begin
        if (transfer_ready) begin
          treq_d  = 1'b0;
          rdy_d   = onehot(owner_q);
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (transfer_done) begin
          rx_d   = from_agent;
          done_d = onehot(owner_q);
          if (!csn[owner_q]) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end else begin
            release_bus = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // A pending byte outranks a session close seen on the same edge.
        if (req[owner_q]) begin
          tx_d    = data_v[owner_q];
          treq_d  = 1'b1;
          state_d = S_ISSUE;
        end else if (csn[owner_q]) begin
          release_bus = 1'b1;
        end else if (HOLD_LIMIT != 0 && hold_q == LIMIT_M1) begin
          release_bus = 1'b1;
        end else if (hold_q != HOLD_CNT_MAX) begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (release_bus) begin
      state_d = S_IDLE;
      last_d  = owner_q;
      gnt_d   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= REQ_UART;
      last_q  <= REQ_POLL;
      hold_q  <= '0;
      div_q   <= '0;
      mode_q  <= '0;
      treq_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      gnt_q   <= '0;
      rdy_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      treq_q  <= treq_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      gnt_q   <= gnt_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign {r1_gnt, r0_gnt}   = gnt_q;
  assign {r1_rdy, r0_rdy}   = rdy_q;
  assign {r1_done, r0_done} = done_q;
  assign rx_byte      = rx_q;
  assign spi_clk_div  = div_q;
  assign cpol         = mode_q[MODE_CPOL];
  assign cpha         = mode_q[MODE_CPHA];
  assign transfer_req = treq_q;
  assign to_agent     = tx_q;
  // Registered grants select the pin, so it cannot dip low while nobody owns the bus.
  assign cs_n = gnt_q[0] ? r0_cs_n : (gnt_q[1] ? r1_cs_n : 1'b1);

endmodule

// File: tb/tb_spi_agent_arbiter.sv
// Directed scenarios then randomized traffic, all checked every cycle against
// a transaction-level model of bus ownership.
module tb_spi_agent_arbiter;
  localparam int HL = 8;

  logic       clk = 0, rst = 1;
  logic       r0_req = 0, r1_req = 0, r0_cs_n = 1, r1_cs_n = 1;
  logic [7:0] r0_data = 0, r1_data = 0, r0_clk_div = 0, r1_clk_div = 0;
  logic [1:0] r0_mode = 0, r1_mode = 0;
  logic       r0_gnt, r1_gnt, r0_rdy, r1_rdy, r0_done, r1_done;
  logic [7:0] rx_byte, spi_clk_div, to_agent;
  logic       cpol, cpha, transfer_req, cs_n;
  logic       transfer_ready = 0, transfer_done = 0;
  logic [7:0] from_agent = 0;

  spi_agent_arbiter #(.HOLD_LIMIT(HL)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_cs_n(r0_cs_n), .r1_cs_n(r1_cs_n),
    .r0_data(r0_data), .r1_data(r1_data), .r0_clk_div(r0_clk_div), .r1_clk_div(r1_clk_div),
    .r0_mode(r0_mode), .r1_mode(r1_mode),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rdy(r0_rdy), .r1_rdy(r1_rdy),
    .r0_done(r0_done), .r1_done(r1_done), .rx_byte(rx_byte),
    .spi_clk_div(spi_clk_div), .cpol(cpol), .cpha(cpha),
    .transfer_req(transfer_req), .transfer_ready(transfer_ready), .transfer_done(transfer_done),
    .to_agent(to_agent), .from_agent(from_agent), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Ownership model: who holds the bus, whether a byte is out to the agent or
  // awaiting its result, and how long the current owner has sat idle.
  int         m_owner, m_last, m_idle;
  bit         m_issue, m_await;
  logic [7:0] m_div, m_data, m_rx;
  logic [1:0] m_mode, m_rdy, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_release();
    m_last  = m_owner;
    m_owner = -1;
  endtask

  task automatic model_step();
    logic [1:0] rq, cs, bid;
    int w;
    rq = {r1_req, r0_req};
    cs = {r1_cs_n, r0_cs_n};
    bid = rq | ~cs;
    m_rdy = 0;
    m_done = 0;
    if (rst) begin
      m_owner = -1; m_last = 1; m_idle = 0; m_issue = 0; m_await = 0;
      m_div = 0; m_mode = 0; m_data = 0; m_rx = 0;
      return;
    end
    if (m_owner < 0) begin
      if (bid != 0) begin
        if (bid == 2'b11) w = 1 - m_last;
        else w = bid[1] ? 1 : 0;
        m_owner = w;
        m_div   = w ? r1_clk_div : r0_clk_div;
        m_mode  = w ? r1_mode : r0_mode;
        m_data  = w ? r1_data : r0_data;
        m_issue = rq[w];
        m_idle  = 0;
      end
    end else if (m_issue) begin
      if (transfer_ready) begin
        m_issue = 0; m_await = 1; m_rdy[m_owner] = 1;
      end
    end else if (m_await) begin
      if (transfer_done) begin
        m_await = 0; m_rx = from_agent; m_done[m_owner] = 1; m_idle = 0;
        if (cs[m_owner]) m_release();
      end
    end else begin
      if (rq[m_owner]) begin
        m_data  = m_owner ? r1_data : r0_data;
        m_issue = 1;
      end else if (cs[m_owner] || (HL != 0 && m_idle + 1 >= HL)) begin
        m_release();
      end else if (m_idle < 65535) begin
        m_idle++;
      end
    end
  endtask

  task automatic compare();
    logic [1:0] eg;
    logic ecs;
    vectors++;
    eg = 0;
    if (m_owner >= 0) eg[m_owner] = 1;
    ecs = (m_owner < 0) ? 1'b1 : (m_owner == 1 ? r1_cs_n : r0_cs_n);
    chk("gnt", 32'({r1_gnt, r0_gnt}), 32'(eg));
    chk("rdy", 32'({r1_rdy, r0_rdy}), 32'(m_rdy));
    chk("done", 32'({r1_done, r0_done}), 32'(m_done));
    chk("rx_byte", 32'(rx_byte), 32'(m_rx));
    chk("spi_clk_div", 32'(spi_clk_div), 32'(m_div));
    chk("cpol", 32'(cpol), 32'(m_mode[1]));
    chk("cpha", 32'(cpha), 32'(m_mode[0]));
    chk("transfer_req", 32'(transfer_req), 32'(m_issue));
    chk("to_agent", 32'(to_agent), 32'(m_data));
    chk("cs_n", 32'(cs_n), 32'(ecs));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  // Agent accepts immediately, then returns rx after one idle cycle.
  task automatic serve(input int who, input logic [7:0] rx);
    transfer_ready = 1; step();
    transfer_ready = 0;
    if (who == 0) r0_req = 0; else r1_req = 0;
    step();
    from_agent = rx; transfer_done = 1; step();
    transfer_done = 0;
  endtask

  int ag_phase = 0, ag_wait = 0;

  task automatic drive_random();
    rst = ($urandom_range(0, 299) == 0);
    if (r0_rdy) r0_req = 0;
    else if (!r0_req && $urandom_range(0, 3) == 0) begin r0_req = 1; r0_data = 8'($urandom); end
    if (r1_rdy) r1_req = 0;
    else if (!r1_req && $urandom_range(0, 3) == 0) begin r1_req = 1; r1_data = 8'($urandom); end
    if ($urandom_range(0, 7) == 0) begin r0_clk_div = 8'($urandom); r0_mode = 2'($urandom); end
    if ($urandom_range(0, 7) == 0) begin r1_clk_div = 8'($urandom); r1_mode = 2'($urandom); end
    if ($urandom_range(0, 15) == 0) r0_cs_n = ~r0_cs_n;
    if ($urandom_range(0, 15) == 0) r1_cs_n = ~r1_cs_n;
    transfer_ready = 0;
    transfer_done  = 0;
    if (rst) ag_phase = 0;
    else if (ag_phase == 0) begin
      if (transfer_req) begin
        if (ag_wait == 0) begin
          transfer_ready = 1; ag_phase = 1; ag_wait = $urandom_range(0, 3);
        end else ag_wait--;
      end else if ($urandom_range(0, 19) == 0) begin
        transfer_done = 1; from_agent = 8'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        transfer_ready = 1;
      end
    end else begin
      if (ag_wait == 0) begin
        transfer_done = 1; from_agent = 8'($urandom); ag_phase = 0; ag_wait = $urandom_range(0, 2);
      end else ag_wait--;
    end
  endtask

  initial begin
    int held;
    // Reset values
    rst = 1; step(); step();
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_treq", 32'(transfer_req), 32'd0);
    chk("rst_gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
    rst = 0;

    // Single transfer and config isolation
    r0_data = 8'hA5; r0_clk_div = 8'h04; r0_mode = 2'b11; r0_req = 1; step();
    chk("t1_treq", 32'(transfer_req), 32'd1);
    chk("t1_to_agent", 32'(to_agent), 32'hA5);
    chk("t1_div", 32'(spi_clk_div), 32'h04);
    chk("t1_cpol_cpha", 32'({cpol, cpha}), 32'd3);
    chk("t1_gnt", 32'(r0_gnt), 32'd1);
    step();
    transfer_ready = 1; step();
    chk("t1_rdy", 32'(r0_rdy), 32'd1);
    transfer_ready = 0; r0_req = 0; r0_clk_div = 8'h10; r0_data = 8'hFF; step();
    chk("t1_div_held", 32'(spi_clk_div), 32'h04);
    from_agent = 8'h3C; transfer_done = 1; step();
    chk("t1_done", 32'(r0_done), 32'd1);
    chk("t1_rx", 32'(rx_byte), 32'h3C);
    chk("t1_cs_n", 32'(cs_n), 32'd1);
    transfer_done = 0;
    r0_req = 1; step();
    chk("t1_div_new", 32'(spi_clk_div), 32'h10);
    serve(0, 8'h5A);

    // Tie breaking from reset
    rst = 1; step(); rst = 0;
    r0_req = 1; r1_req = 1; step();
    chk("tie1_r0", 32'({r1_gnt, r0_gnt}), 32'b01);
    serve(0, 8'h01);
    r0_req = 1; step();
    chk("tie2_r1", 32'({r1_gnt, r0_gnt}), 32'b10);
    serve(1, 8'h02);
    r1_req = 1; step();
    chk("tie3_r0", 32'({r1_gnt, r0_gnt}), 32'b01);
    serve(0, 8'h03);

    // Session lock: r1 holds across two bytes while r0 waits
    r1_cs_n = 0; r1_data = 8'h11; r1_req = 1; r0_req = 1; step();
    chk("lock_r1", 32'(r1_gnt), 32'd1);
    chk("lock_cs0", 32'(cs_n), 32'd0);
    serve(1, 8'hAA);
    chk("lock_r0_wait", 32'(r0_gnt), 32'd0);
    r1_data = 8'h22; r1_req = 1; step();
    chk("lock_byte2", 32'(to_agent), 32'h22);
    serve(1, 8'hBB);
    chk("lock_cs1", 32'(cs_n), 32'd0);
    chk("lock_r0_wait2", 32'(r0_gnt), 32'd0);
    r1_cs_n = 1; step();
    chk("lock_rel", 32'(cs_n), 32'd1);
    step();
    chk("lock_r0_served", 32'(r0_gnt), 32'd1);
    serve(0, 8'h04);

    // Forced release after HL idle hold cycles
    r0_cs_n = 0; step();
    held = 0;
    for (int k = 0; k < 20 && r0_gnt; k++) begin
      held++;
      if (k == 2) r1_req = 1;
      step();
    end
    chk("hold_len", 32'(held), 32'(HL));
    chk("hold_cs_n", 32'(cs_n), 32'd1);
    step();
    chk("hold_r1", 32'(r1_gnt), 32'd1);
    r0_cs_n = 1;
    serve(1, 8'h05);

    // Reset during the wait for the agent's result
    r0_req = 1; step();
    transfer_ready = 1; step();
    transfer_ready = 0; r0_req = 0; step();
    rst = 1; transfer_done = 1; from_agent = 8'h77; step();
    chk("rstx_done", 32'(r0_done), 32'd0);
    chk("rstx_rx", 32'(rx_byte), 32'd0);
    chk("rstx_gnt", 32'(r0_gnt), 32'd0);
    rst = 0; transfer_done = 0; step();
    chk("rstx_done2", 32'(r0_done), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
